// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line idle level and FSM state encodings.
// Used by axis_uart_tx and intended for reuse by a future axis_uart_rx.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);
  localparam logic        IDLE_LEVEL = 1'b1;

  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Even parity bit for a data byte (XOR of all data bits).
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick_c
// (combinationally) in the last cycle of each bit. Deasserting en restarts the count at 0.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == CNT_MAX);

  // Counter restarts at each bit edge and is held at zero while disabled.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (!en || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream byte sink that serialises each accepted byte onto a UART TX line
// (8N1, LSB first). Backpressures upstream while a frame is on the wire.
// Build option: define AXIS_UART_TX_PARITY_EN to insert an even parity bit (8E1).
module axis_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic [STATE_W-1:0]   state_q,   state_nxt;
  logic [DATA_BITS-1:0] shift_q,   shift_nxt;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_nxt;
  logic                 txd_nxt;
  logic                 tready_nxt;
  logic                 busy_nxt;
  logic                 bit_tick_c;
`ifdef AXIS_UART_TX_PARITY_EN
  logic                 parity_q,  parity_nxt;
`endif

  // Bit timer runs whenever a frame is in progress.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (state_q != ST_IDLE),
    .tick_c  (bit_tick_c)
  );

  // State, shift register and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      txd           <= IDLE_LEVEL;
      s_axis_tready <= 1'b0;
      busy          <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_nxt;
      shift_q       <= shift_nxt;
      bit_idx_q     <= bit_idx_nxt;
      txd           <= txd_nxt;
      s_axis_tready <= tready_nxt;
      busy          <= busy_nxt;
`ifdef AXIS_UART_TX_PARITY_EN
      parity_q      <= parity_nxt;
`endif
    end
  end

  // Next-state and next-output logic; line level for the upcoming bit is set at each bit edge.
  always_comb begin
    state_nxt   = state_q;
    shift_nxt   = shift_q;
    bit_idx_nxt = bit_idx_q;
    txd_nxt     = txd;
    tready_nxt  = s_axis_tready;
    busy_nxt    = busy;
`ifdef AXIS_UART_TX_PARITY_EN
    parity_nxt  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tready_nxt = 1'b1;
        txd_nxt    = IDLE_LEVEL;
        if (s_axis_tvalid && s_axis_tready) begin
          shift_nxt   = s_axis_tdata;
          bit_idx_nxt = '0;
          tready_nxt  = 1'b0;
          busy_nxt    = 1'b1;
          txd_nxt     = ~IDLE_LEVEL;
          state_nxt   = ST_START;
`ifdef AXIS_UART_TX_PARITY_EN
          parity_nxt  = even_parity(s_axis_tdata);
`endif
        end
      end

      ST_START: begin
        if (bit_tick_c) begin
          txd_nxt   = shift_q[0];
          state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_tick_c) begin
          shift_nxt = shift_q >> 1;
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef AXIS_UART_TX_PARITY_EN
            txd_nxt   = parity_q;
            state_nxt = ST_PARITY;
`else
            txd_nxt   = IDLE_LEVEL;
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx_q + BIT_IDX_W'(1);
            txd_nxt     = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick_c) begin
          txd_nxt   = IDLE_LEVEL;
          state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_tick_c) begin
          busy_nxt   = 1'b0;
          tready_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end

      default: begin
        txd_nxt    = IDLE_LEVEL;
        tready_nxt = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx at CLKS_PER_BIT=10.
// Honours AXIS_UART_TX_PARITY_EN the same way as the design (11-bit frames).
module tb_axis_uart_tx;

  localparam int unsigned CPB = 10;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       txd;
  logic       busy;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  axis_uart_tx #(
    .CLK_FREQ (100000000),
    .BAUD     (10000000)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .txd           (txd),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Expected wire bits, LSB = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef AXIS_UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Called at the first sample after the handshake edge; walks the whole frame.
  task automatic recv(input string tag, input logic [7:0] d, input bit wiggle);
    logic [10:0] fr;
    int          low;
    bit          ok;
    bit          bok;
    fr  = frame_of(d);
    low = 0;
    bok = 1'b1;
    for (int b = 0; b < int'(NB); b++) begin
      ok = 1'b1;
      for (int c = 0; c < int'(CPB); c++) begin
        if (txd !== fr[b]) ok = 1'b0;
        if (s_axis_tready === 1'b0) low++;
        if (busy !== ~s_axis_tready) bok = 1'b0;
        if (wiggle) begin
          s_axis_tvalid = 1'($urandom_range(0, 1));
          s_axis_tdata  = 8'($urandom);
        end
        step();
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(ok), 32'd1);
    end
    if (wiggle) s_axis_tvalid = 1'b0;
    check({tag, "_tready_low_cycles"}, 32'(low), 32'(NB * CPB));
    check({tag, "_busy_mirror"}, 32'(bok), 32'd1);
    check({tag, "_txd_idle"}, 32'(txd), 32'd1);
    check({tag, "_tready_back"}, 32'(s_axis_tready), 32'd1);
    check({tag, "_busy_clear"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t0;
    int t1;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;

    // 1: reset held 5 cycles, then tready rises on the first edge after release
    repeat (5) step();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    aresetn = 1'b1;
    step();
    check("rel_tready", 32'(s_axis_tready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    repeat (3) step();

    // 2: single byte 0x55
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h55;
    step();
    s_axis_tvalid = 1'b0;
    check("b55_txd_start", 32'(txd), 32'd0);
    recv("b55", 8'h55, 1'b0);
    repeat (4) step();

    // 3: back-to-back 0xA3 then 0x0F with tvalid held high
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hA3;
    step();
    t0 = cyc;
    s_axis_tdata = 8'h0F;
    recv("bA3", 8'hA3, 1'b0);
    step();
    t1 = cyc;
    s_axis_tvalid = 1'b0;
    check("b2b_start_gap", 32'(t1 - t0), 32'(NB * CPB + 1));
    check("b0F_txd_start", 32'(txd), 32'd0);
    recv("b0F", 8'h0F, 1'b0);

    // 4: upstream wiggles tvalid/tdata during a 0xC6 frame
    repeat (3) step();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hC6;
    step();
    s_axis_tvalid = 1'b0;
    recv("bC6", 8'hC6, 1'b1);
    repeat (5) step();
    check("bp_no_extra_txd", 32'(txd), 32'd1);
    check("bp_no_extra_busy", 32'(busy), 32'd0);
    check("bp_no_extra_tready", 32'(s_axis_tready), 32'd1);

    // 5: reset 45 cycles into a 0xFF frame, then 0x81 sends cleanly
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hFF;
    step();
    s_axis_tvalid = 1'b0;
    check("bFF_txd_start", 32'(txd), 32'd0);
    repeat (45) step();
    check("bFF_busy_mid", 32'(busy), 32'd1);
    aresetn = 1'b0;
    step();
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_tready", 32'(s_axis_tready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    check("midrst_tready_hold", 32'(s_axis_tready), 32'd0);
    aresetn = 1'b1;
    step();
    check("midrst_rel_tready", 32'(s_axis_tready), 32'd1);
    repeat (20) step();
    check("midrst_no_resend", 32'(txd), 32'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h81;
    step();
    s_axis_tvalid = 1'b0;
    recv("b81", 8'h81, 1'b0);

`ifdef AXIS_UART_TX_PARITY_EN
    // 6: even parity bit, 0x07 -> 1 and 0x03 -> 0
    repeat (2) step();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h07;
    step();
    s_axis_tvalid = 1'b0;
    repeat (90) step();
    check("p07_parity", 32'(txd), 32'd1);
    repeat (20) step();
    check("p07_frame_end", 32'(s_axis_tready), 32'd1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h03;
    step();
    s_axis_tvalid = 1'b0;
    repeat (90) step();
    check("p03_parity", 32'(txd), 32'd0);
    repeat (20) step();
    check("p03_frame_end", 32'(s_axis_tready), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
